// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - decode-to-execute pipeline bundle: decoded fields in, registered copies out
interface id_ex_reg_if #(
    parameter int DW = 32
);
    logic          valid_i;
    logic [DW-1:0] data1_i;
    logic [DW-1:0] data2_i;
    logic [DW-1:0] imm_i;
    logic [4:0]    rs_i;
    logic [4:0]    rt_i;
    logic [4:0]    rd_i;
    logic [2:0]    ALUCtrl_i;
    logic          ALUSrc_i;
    logic          RegDst_i;
    logic          RegWrite_i;
    logic          MemtoReg_i;
    logic          MemRead_i;
    logic          MemWrite_i;

    logic          valid_o;
    logic [DW-1:0] data1_o;
    logic [DW-1:0] data2_o;
    logic [DW-1:0] imm_o;
    logic [4:0]    rs_o;
    logic [4:0]    rt_o;
    logic [4:0]    rd_o;
    logic [2:0]    ALUCtrl_o;
    logic          ALUSrc_o;
    logic          RegDst_o;
    logic          RegWrite_o;
    logic          MemtoReg_o;
    logic          MemRead_o;
    logic          MemWrite_o;
    logic [15:0]   bubble_cnt_o;

    // decode side drives the *_i fields
    modport master (
        output valid_i, data1_i, data2_i, imm_i, rs_i, rt_i, rd_i, ALUCtrl_i,
               ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        input  valid_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o, ALUCtrl_o,
               ALUSrc_o, RegDst_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               bubble_cnt_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, imm_i, rs_i, rt_i, rd_i, ALUCtrl_i,
               ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        output valid_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o, ALUCtrl_o,
               ALUSrc_o, RegDst_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with freeze, bubble insertion and bubble counter
module id_ex_reg #(
    parameter int DW = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    id_ex_reg_if.slave  bus
);
    localparam logic [2:0]  ALU_ADD = 3'b010;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic          r_valid;
    logic [DW-1:0] r_data1;
    logic [DW-1:0] r_data2;
    logic [DW-1:0] r_imm;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_rd;
    logic [2:0]    r_alu_ctrl;
    logic          r_alu_src;
    logic          r_reg_dst;
    logic          r_reg_write;
    logic          r_mem_to_reg;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [15:0]   r_bubble_cnt;

    logic          w_load;
    logic          w_bubble;

    // stall outranks flush: a flush seen during a freeze is dropped
    assign w_load   = !stall_i && !flush_i;
    assign w_bubble = !stall_i &&  flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_ctrl   <= ALU_ADD;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (w_bubble) begin
            // bubble computes 0+0 and has no side effects
            r_valid      <= 1'b0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_ctrl   <= ALU_ADD;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (w_load) begin
            // fields are captured even when valid_i is low; gating happens upstream
            r_valid      <= bus.valid_i;
            r_data1      <= bus.data1_i;
            r_data2      <= bus.data2_i;
            r_imm        <= bus.imm_i;
            r_rs         <= bus.rs_i;
            r_rt         <= bus.rt_i;
            r_rd         <= bus.rd_i;
            r_alu_ctrl   <= bus.ALUCtrl_i;
            r_alu_src    <= bus.ALUSrc_i;
            r_reg_dst    <= bus.RegDst_i;
            r_reg_write  <= bus.RegWrite_i;
            r_mem_to_reg <= bus.MemtoReg_i;
            r_mem_read   <= bus.MemRead_i;
            r_mem_write  <= bus.MemWrite_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.valid_o      = r_valid;
    assign bus.data1_o      = r_data1;
    assign bus.data2_o      = r_data2;
    assign bus.imm_o        = r_imm;
    assign bus.rs_o         = r_rs;
    assign bus.rt_o         = r_rt;
    assign bus.rd_o         = r_rd;
    assign bus.ALUCtrl_o    = r_alu_ctrl;
    assign bus.ALUSrc_o     = r_alu_src;
    assign bus.RegDst_o     = r_reg_dst;
    assign bus.RegWrite_o   = r_reg_write;
    assign bus.MemtoReg_o   = r_mem_to_reg;
    assign bus.MemRead_o    = r_mem_read;
    assign bus.MemWrite_o   = r_mem_write;
    assign bus.bubble_cnt_o = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - scoreboard bench for id_ex_reg
module tb_id_ex_reg;
    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    always #5 clk = ~clk;

    id_ex_reg_if #(.DW(32)) bus ();

    id_ex_reg #(.DW(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus)
    );

    // ctrl = {ALUSrc, RegDst, RegWrite, MemtoReg, MemRead, MemWrite}
    typedef struct packed {
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic [5:0]  ctrl;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic [15:0] cnt;
    } out_t;

    out_t    q[$];
    out_t    model;
    int      checks = 0;
    int      errors = 0;
    fields_t vec[4];

    function automatic fields_t mk(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [2:0] alu, input logic [5:0] ctrl);
        fields_t r;
        r.valid = v; r.d1 = d1; r.d2 = d2; r.imm = imm;
        r.rs = rs; r.rt = rt; r.rd = rd; r.alu = alu; r.ctrl = ctrl;
        return r;
    endfunction

    function automatic fields_t nop_f();
        return mk(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'b010, 6'b000000);
    endfunction

    function automatic out_t sample();
        out_t r;
        r.f.valid = bus.valid_o;
        r.f.d1    = bus.data1_o;
        r.f.d2    = bus.data2_o;
        r.f.imm   = bus.imm_o;
        r.f.rs    = bus.rs_o;
        r.f.rt    = bus.rt_o;
        r.f.rd    = bus.rd_o;
        r.f.alu   = bus.ALUCtrl_o;
        r.f.ctrl  = {bus.ALUSrc_o, bus.RegDst_o, bus.RegWrite_o,
                     bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o};
        r.cnt     = bus.bubble_cnt_o;
        return r;
    endfunction

    task automatic cmp_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input fields_t in);
        bus.valid_i    = in.valid;
        bus.data1_i    = in.d1;
        bus.data2_i    = in.d2;
        bus.imm_i      = in.imm;
        bus.rs_i       = in.rs;
        bus.rt_i       = in.rt;
        bus.rd_i       = in.rd;
        bus.ALUCtrl_i  = in.alu;
        {bus.ALUSrc_i, bus.RegDst_i, bus.RegWrite_i,
         bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i} = in.ctrl;
    endtask

    // drives one edge's worth of stimulus and queues the response expected after that edge
    task automatic step(input logic s, input logic f, input fields_t in);
        @(negedge clk);
        #1;
        stall = s;
        flush = f;
        drive(in);
        if (!s) begin
            if (f) begin
                model.f = nop_f();
                if (model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
            end else begin
                model.f = in;
            end
        end
        q.push_back(model);
    endtask

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            cmp_out("scoreboard", sample(), q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fields_t busy;
        busy = mk(1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_FFF0, 5'd7, 5'd8, 5'd9, 3'b111, 6'b111111);
        vec[0] = mk(1'b1, 32'h0000_0011, 32'h0000_0022, 32'h0000_0004, 5'd1,  5'd2,  5'd3,  3'b010, 6'b101000);
        vec[1] = mk(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FF80, 5'd4,  5'd5,  5'd6,  3'b110, 6'b011000);
        vec[2] = mk(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_7FFF, 5'd31, 5'd30, 5'd29, 3'b000, 6'b100110);
        vec[3] = mk(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd10, 5'd11, 5'd12, 3'b001, 6'b100001);

        rst   = 1'b1;
        stall = 1'b1;
        flush = 1'b0;
        drive(busy);
        model.f   = nop_f();
        model.cnt = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        cmp_out("reset_state", sample(), model);
        rst = 1'b0;

        // pass-through: each vector shows up one edge after it is driven
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, vec[i]);
        step(1'b0, 1'b0, mk(1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 3'b010, 6'b001000));
        chk("pass_last", 64'(sample().f), 64'(vec[3]));
        chk("pass_valid_low_kept_rd", 64'(vec[2].rd), 64'd29);

        // stall for 3 edges while inputs change
        step(1'b1, 1'b0, vec[0]);
        step(1'b1, 1'b0, vec[1]);
        chk("stall_rd", 64'(bus.rd_o), 64'd9);
        chk("stall_regwrite", 64'(bus.RegWrite_o), 64'd1);
        step(1'b1, 1'b0, vec[2]);
        chk("stall_rd_2", 64'(bus.rd_o), 64'd9);
        step(1'b0, 1'b0, vec[3]);
        chk("stall_rd_3", 64'(bus.rd_o), 64'd9);
        step(1'b0, 1'b1, mk(1'b1, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 3'b111, 6'b000001));
        chk("after_stall_rd", 64'(bus.rd_o), 64'd12);

        // flush with MemWrite requested on the inputs
        step(1'b0, 1'b0, vec[0]);
        chk("flush_memwrite", 64'(bus.MemWrite_o), 64'd0);
        chk("flush_valid", 64'(bus.valid_o), 64'd0);
        chk("flush_alu", 64'(bus.ALUCtrl_o), 64'd2);
        chk("flush_cnt", 64'(bus.bubble_cnt_o), 64'd1);

        // stall and flush together: stall wins, flush lost
        step(1'b1, 1'b1, vec[1]);
        step(1'b0, 1'b1, vec[2]);
        chk("stallflush_rd", 64'(bus.rd_o), 64'd3);
        chk("stallflush_cnt", 64'(bus.bubble_cnt_o), 64'd1);
        step(1'b0, 1'b1, vec[3]);
        chk("dbl_flush_cnt", 64'(bus.bubble_cnt_o), 64'd2);

        // asynchronous reset between edges with nonzero inputs
        step(1'b1, 1'b0, busy);
        chk("pre_reset_cnt", 64'(bus.bubble_cnt_o), 64'd3);
        @(negedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model.f   = nop_f();
        model.cnt = 16'd0;
        cmp_out("async_reset", sample(), model);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, mk(1'b1, 32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd3, 3'b110, 6'b001000));
        step(1'b1, 1'b0, busy);
        chk("post_reset_d1", 64'(bus.data1_o), 64'd5);
        chk("post_reset_d2", 64'(bus.data2_o), 64'd3);
        chk("post_reset_alu", 64'(bus.ALUCtrl_o), 64'd6);

        // saturation: drive the count up to FFFE, then three more flush edges
        for (int i = 0; i < 65534; i++) step(1'b0, 1'b1, busy);
        step(1'b0, 1'b1, busy);
        chk("cnt_fffe", 64'(bus.bubble_cnt_o), 64'hFFFE);
        step(1'b0, 1'b1, busy);
        step(1'b0, 1'b1, busy);
        chk("cnt_sat_1", 64'(bus.bubble_cnt_o), 64'hFFFF);
        step(1'b0, 1'b0, vec[0]);
        chk("cnt_sat_2", 64'(bus.bubble_cnt_o), 64'hFFFF);
        step(1'b1, 1'b0, vec[1]);
        chk("cnt_sat_load", 64'(bus.bubble_cnt_o), 64'hFFFF);

        @(negedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
